mem_issue_queue: RTL
====================

Name: mem_issue_queue

Overview:
- In-order issue queue feeding the memory execute stage (regfile read, then the MemoryBlock pipe).
- Buffers dispatched load/store/cacop micro-ops and tracks source-operand readiness from writeback wakeups.
- Issues the oldest entry only, once both sources are ready and the downstream stage accepts.
- Strict program order is kept so stores and loads reach the DCache in order.

Parameters:
DEPTH, 8, number of queue entries; power of two, >= 2
PREG_W, 6, physical register index width
WB_PORTS, 4, number of writeback wakeup ports
PAYLOAD_W, 96, opaque payload width (rob_idx, imm, mem_op, align_op, micro, code, pdest, pdest_valid, llbit)

Ports:
clk  in  1  clock
a_rst_n  in  1  asynchronous reset, active low
flush_i  in  1  pipeline flush; empties the queue
dis_valid_i  in  1  dispatch request
dis_ready_o  out  1  queue can accept a dispatch this cycle
dis_psrc0_i  in  PREG_W  source 0 physical register
dis_psrc0_rdy_i  in  1  source 0 already ready at rename
dis_psrc1_i  in  PREG_W  source 1 physical register
dis_psrc1_rdy_i  in  1  source 1 already ready at rename
dis_payload_i  in  PAYLOAD_W  opaque micro-op payload
wake_valid_i  in  WB_PORTS  wakeup valid per port
wake_preg_i  in  WB_PORTS*PREG_W  woken physical register per port, port k at bits [k*PREG_W +: PREG_W]
iss_valid_o  out  1  head entry valid with both sources ready
iss_ready_i  in  1  downstream accepts the issue
iss_psrc0_o  out  PREG_W  head source 0
iss_psrc1_o  out  PREG_W  head source 1
iss_payload_o  out  PAYLOAD_W  head payload
count_o  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset is asynchronous on a_rst_n low. Queue empties; head, tail and count all go to 0.
- Reset output values: iss_valid_o=0, count_o=0, dis_ready_o=1; iss_psrc0_o, iss_psrc1_o and iss_payload_o = 0.
- Storage is a circular buffer of DEPTH entries.
- Each entry holds psrc0, rdy0, psrc1, rdy1 and payload. Occupancy is tracked by head/tail pointers plus count; pointers wrap modulo DEPTH.
- dis_ready_o = (count < DEPTH). It is not raised by a same-cycle issue when the queue is full, so there is no full-queue bypass.
- Dispatch fires on dis_valid_i & dis_ready_o & ~flush_i. The entry is written at tail and tail increments.
- Ready bit captured at dispatch, per source: rdyN = dis_psrcN_rdy_i | (dis_psrcN_i == 0) | (hit on any valid wakeup port this same cycle).
- Wakeup: each cycle, every valid entry with rdyN==0 whose psrcN equals any valid wake_preg sets rdyN=1 on the next edge.
- Issue uses registered state only. iss_valid_o = (count != 0) & head.rdy0 & head.rdy1.
  - A wakeup therefore makes the head issuable at the earliest in the following cycle.
  - Issue latency is at least 1 cycle after dispatch, even when sources are ready at dispatch.
- iss_* outputs are driven combinationally from the head entry. Issue fires on iss_valid_o & iss_ready_i: head increments and the entry is invalidated.
- Simultaneous dispatch and issue: count is unchanged and both pointers advance. This is legal when not full, including count==1 with the head issuing.
- Older-not-ready blocks younger-ready. Only the head may issue.
- Flush has priority over dispatch, issue and wakeup. On the next edge head=tail=count=0. dis_ready_o stays asserted during the flush cycle, but dispatch is ignored.
- Wakeup of an empty slot has no effect. Duplicate wakeups across ports are harmless.
- iss_valid_o may drop without a handshake only through flush; otherwise it stays stable until accepted.

Decomposition:
- Pipeline.svh gets a MemIqEntrySt typedef (psrc0, rdy0, psrc1, rdy1, payload) and a MEM_IQ_DEPTH constant.
- Pipeline.svh also gets a MemIqDisSt grouping the dispatch fields for the top-level connection.
- One natural sub-module: mem_iq_wakeup_cam. Per source it does the PREG_W compare against all WB_PORTS and outputs the hit vector. It is instantiated 2*DEPTH+2 times (entries plus the dispatch-path bypass).

Test Plan:
- Reset, then dispatch psrc0=3 (rdy=1), psrc1=0 (rdy=0) with iss_ready_i=1 -> iss_valid_o=1 the next cycle with that payload; count_o goes 1 then 0.
- Dispatch psrc0=5 (rdy=0); wake port 2 with preg=5 two cycles later -> iss_valid_o rises exactly one cycle after the wake cycle.
- Dispatch A (not ready), then B (ready) -> B is not issued until A's wakeup arrives; issue order is A then B.
- Fill 8 entries with iss_ready_i=0 -> dis_ready_o=0 at count_o=8; the 9th dis_valid_i is held off. Raise iss_ready_i -> dis_ready_o=1 the next cycle; pointers wrap correctly over 20 ops.
- Dispatch with psrc1=7 while wake_preg=7 is valid in the same cycle -> the entry is ready at capture and issues the next cycle.
- Flush with count_o=5 while simultaneously dispatching and issuing -> count_o=0 and iss_valid_o=0 the next cycle; the dispatched op is discarded. Repeat with a_rst_n asserted mid-stream -> outputs return to their reset values immediately.

Source files
------------

// File: rtl/mem_issue_queue_pkg.sv
// Shared constants and entry/dispatch record types for the memory issue queue.
// Types use the default sizing; parameterised instances carry their own local records.
package mem_issue_queue_pkg;

    localparam int MEM_IQ_DEPTH     = 8;
    localparam int MEM_IQ_PREG_W    = 6;
    localparam int MEM_IQ_WB_PORTS  = 4;
    localparam int MEM_IQ_PAYLOAD_W = 96;

    typedef struct packed {
        logic [MEM_IQ_PREG_W-1:0]    psrc0;
        logic                        rdy0;
        logic [MEM_IQ_PREG_W-1:0]    psrc1;
        logic                        rdy1;
        logic [MEM_IQ_PAYLOAD_W-1:0] payload;
    } MemIqEntrySt;

    typedef struct packed {
        logic [MEM_IQ_PREG_W-1:0]    psrc0;
        logic                        psrc0_rdy;
        logic [MEM_IQ_PREG_W-1:0]    psrc1;
        logic                        psrc1_rdy;
        logic [MEM_IQ_PAYLOAD_W-1:0] payload;
    } MemIqDisSt;

endpackage

// File: rtl/mem_iq_wakeup_cam.sv
// Compares one source register against every writeback wakeup port.
// Purely combinational; no flow control.
module mem_iq_wakeup_cam #(
    parameter int PREG_W   = 6,
    parameter int WB_PORTS = 4
) (
    input  logic [PREG_W-1:0]          preg_i,
    input  logic [WB_PORTS-1:0]        wake_valid_i,
    input  logic [WB_PORTS*PREG_W-1:0] wake_preg_i,
    output logic [WB_PORTS-1:0]        hit_o
);

    always_comb begin
        hit_o = '0;
        for (int k = 0; k < WB_PORTS; k++) begin
            hit_o[k] = wake_valid_i[k] & (wake_preg_i[k*PREG_W +: PREG_W] == preg_i);
        end
    end

endmodule

// File: rtl/mem_issue_queue.sv
// In-order issue queue for the memory pipe: issues only the head once both sources are ready.
// Issue is >=1 cycle after dispatch; dispatch stalls when full (no bypass), issue waits on iss_ready_i.
module mem_issue_queue
    import mem_issue_queue_pkg::*;
#(
    parameter int DEPTH     = MEM_IQ_DEPTH,
    parameter int PREG_W    = MEM_IQ_PREG_W,
    parameter int WB_PORTS  = MEM_IQ_WB_PORTS,
    parameter int PAYLOAD_W = MEM_IQ_PAYLOAD_W
) (
    input  logic                        clk,
    input  logic                        a_rst_n,
    input  logic                        flush_i,
    input  logic                        dis_valid_i,
    output logic                        dis_ready_o,
    input  logic [PREG_W-1:0]           dis_psrc0_i,
    input  logic                        dis_psrc0_rdy_i,
    input  logic [PREG_W-1:0]           dis_psrc1_i,
    input  logic                        dis_psrc1_rdy_i,
    input  logic [PAYLOAD_W-1:0]        dis_payload_i,
    input  logic [WB_PORTS-1:0]         wake_valid_i,
    input  logic [WB_PORTS*PREG_W-1:0]  wake_preg_i,
    output logic                        iss_valid_o,
    input  logic                        iss_ready_i,
    output logic [PREG_W-1:0]           iss_psrc0_o,
    output logic [PREG_W-1:0]           iss_psrc1_o,
    output logic [PAYLOAD_W-1:0]        iss_payload_o,
    output logic [$clog2(DEPTH):0]      count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [PREG_W-1:0]    psrc0;
        logic                 rdy0;
        logic [PREG_W-1:0]    psrc1;
        logic                 rdy1;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [WB_PORTS-1:0] hit0 [DEPTH];
    logic [WB_PORTS-1:0] hit1 [DEPTH];
    logic [WB_PORTS-1:0] dis_hit0, dis_hit1;

    entry_t head_e;
    entry_t dis_e;
    logic   dis_fire;
    logic   iss_fire;

    for (genvar g = 0; g < DEPTH; g++) begin : g_ent_cam
        mem_iq_wakeup_cam #(.PREG_W(PREG_W), .WB_PORTS(WB_PORTS)) u_cam0 (
            .preg_i       (mem_q[g].psrc0),
            .wake_valid_i (wake_valid_i),
            .wake_preg_i  (wake_preg_i),
            .hit_o        (hit0[g])
        );
        mem_iq_wakeup_cam #(.PREG_W(PREG_W), .WB_PORTS(WB_PORTS)) u_cam1 (
            .preg_i       (mem_q[g].psrc1),
            .wake_valid_i (wake_valid_i),
            .wake_preg_i  (wake_preg_i),
            .hit_o        (hit1[g])
        );
    end

    // Same-cycle wakeup bypass so a dispatching op never misses a broadcast.
    mem_iq_wakeup_cam #(.PREG_W(PREG_W), .WB_PORTS(WB_PORTS)) u_dis_cam0 (
        .preg_i       (dis_psrc0_i),
        .wake_valid_i (wake_valid_i),
        .wake_preg_i  (wake_preg_i),
        .hit_o        (dis_hit0)
    );
    mem_iq_wakeup_cam #(.PREG_W(PREG_W), .WB_PORTS(WB_PORTS)) u_dis_cam1 (
        .preg_i       (dis_psrc1_i),
        .wake_valid_i (wake_valid_i),
        .wake_preg_i  (wake_preg_i),
        .hit_o        (dis_hit1)
    );

    assign head_e        = mem_q[head_q];
    assign dis_ready_o   = count_q < CNT_W'(DEPTH);
    assign iss_valid_o   = (count_q != '0) & head_e.rdy0 & head_e.rdy1;
    assign iss_psrc0_o   = head_e.psrc0;
    assign iss_psrc1_o   = head_e.psrc1;
    assign iss_payload_o = head_e.payload;
    assign count_o       = count_q;

    assign dis_fire = dis_valid_i & dis_ready_o & ~flush_i;
    assign iss_fire = iss_valid_o & iss_ready_i & ~flush_i;

    always_comb begin
        dis_e         = '0;
        dis_e.psrc0   = dis_psrc0_i;
        dis_e.rdy0    = dis_psrc0_rdy_i | (dis_psrc0_i == '0) | (|dis_hit0);
        dis_e.psrc1   = dis_psrc1_i;
        dis_e.rdy1    = dis_psrc1_rdy_i | (dis_psrc1_i == '0) | (|dis_hit1);
        dis_e.payload = dis_payload_i;
    end

    // Waking a free slot is harmless: the next dispatch overwrites the whole entry.
    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (|hit0[i]) mem_d[i].rdy0 = 1'b1;
            if (|hit1[i]) mem_d[i].rdy1 = 1'b1;
        end
        if (dis_fire) begin
            mem_d[tail_q] = dis_e;
            tail_d        = tail_q + 1'b1;
        end
        if (iss_fire) head_d = head_q + 1'b1;
        count_d = count_q + CNT_W'(dis_fire) - CNT_W'(iss_fire);
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

endmodule
